// File: rtl/ecg_cnn_sched_pkg.sv
// Shared constants and helpers for the ECG CNN shared-multiplier scheduler.
// rr_pick is written for up to MAXREQ requesters; callers zero-pad narrower vectors.
package ecg_cnn_sched_pkg;

    localparam int AW     = 25;
    localparam int BW     = 18;
    localparam int PW     = AW + BW;
    localparam int MAXREQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        return r;
    endfunction

    // First valid index scanning ptr, ptr+1, ... wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int                nreq);
        rr_pick_t p;
        int       j;
        p = '0;
        for (int k = 0; k < MAXREQ; k++) begin
            if (k < nreq && !p.found) begin
                j = int'(ptr) + k;
                if (j >= nreq) j = j - nreq;
                if (valid[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ecg_cnn_mul_25ns_18ns_43_1_0.sv
// Unsigned 25x18 multiplier core, combinational, full-width product.
module ecg_cnn_mul_25ns_18ns_43_1_0 #(
    parameter int din0_WIDTH = 25,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 43
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);

endmodule

// File: rtl/ecg_cnn_rr_arbiter.sv
// Rotating-priority picker with a pointer that advances only on an accepted grant.
module ecg_cnn_rr_arbiter
    import ecg_cnn_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic            free_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            accept_o
);

    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    rr_ptr_d;
    logic [MAXREQ-1:0] valid_pad;
    logic [2:0]        ptr_pad;
    rr_pick_t          pick;

    always_comb begin
        valid_pad   = MAXREQ'(req_valid_i);
        ptr_pad     = 3'(rr_ptr_q);
        pick        = rr_pick(valid_pad, ptr_pad, NREQ);
        grant_idx_o = IDW'(pick.idx);
    end

    // Readiness never looks at operand data, only at who is asking and slot state.
    assign accept_o = pick.found & free_i & ~rst_i;

    always_comb begin
        req_ready_o = '0;
        if (accept_o) req_ready_o[grant_idx_o] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_o) begin
            if (grant_idx_o == IDW'(NREQ - 1)) rr_ptr_d = '0;
            else                               rr_ptr_d = grant_idx_o + IDW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/ecg_cnn_mul_rr_sched.sv
// Time-shares one unsigned 25x18 multiplier among NREQ requesters; one registered,
// ID-tagged, back-pressured result slot.
module ecg_cnn_mul_rr_sched
    import ecg_cnn_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ),
    parameter int AW   = ecg_cnn_sched_pkg::AW,
    parameter int BW   = ecg_cnn_sched_pkg::BW,
    parameter int PW   = AW + BW
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PW-1:0]      res_data,
    output logic [IDW-1:0]     res_id,
    output logic [31:0]        op_count
);

    logic           res_valid_q, res_valid_d;
    logic [PW-1:0]  res_data_q,  res_data_d;
    logic [IDW-1:0] res_id_q,    res_id_d;
    logic [31:0]    op_count_q,  op_count_d;

    logic           free;
    logic           accept;
    logic [IDW-1:0] grant_idx;
    logic [AW-1:0]  a_sel;
    logic [BW-1:0]  b_sel;
    logic [PW-1:0]  product;

    // The slot is free if empty or being drained this same cycle.
    assign free = ~res_valid_q | res_ready;

    ecg_cnn_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .req_valid_i (req_valid),
        .free_i      (free),
        .req_ready_o (req_ready),
        .grant_idx_o (grant_idx),
        .accept_o    (accept)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[i*AW +: AW];
                b_sel = req_b[i*BW +: BW];
            end
        end
    end

    ecg_cnn_mul_25ns_18ns_43_1_0 #(
        .din0_WIDTH (AW),
        .din1_WIDTH (BW),
        .dout_WIDTH (PW)
    ) u_mul (
        .din0 (a_sel),
        .din1 (b_sel),
        .dout (product)
    );

    // Data and ID only change on accept, so a drained slot keeps its last value.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        op_count_d  = op_count_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_data_d  = product;
            res_id_d    = grant_idx;
            op_count_d  = op_count_q + 32'd1;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ecg_cnn_mul_rr_sched.sv
// Scoreboard bench for the shared-multiplier round-robin scheduler.
module tb_ecg_cnn_mul_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int AW   = 25;
    localparam int BW   = 18;
    localparam int PW   = 43;

    logic               ap_clk;
    logic               ap_rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic [PW-1:0]      res_data;
    logic [IDW-1:0]     res_id;
    logic [31:0]        op_count;

    ecg_cnn_mul_rr_sched #(.NREQ(NREQ)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    // clock / reset
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // reference model state: priority start, slot occupancy, accepted count
    int                    m_ptr;
    logic                  m_rv;
    int unsigned           m_cnt;
    logic [PW+IDW-1:0]     exp_q[$];
    int                    total;
    int                    bad;
    logic [AW-1:0]         da[NREQ];
    logic [BW-1:0]         db[NREQ];
    int                    wait_ops[NREQ];
    logic [NREQ-1:0]       last_gnt;
    logic [NREQ-1:0]       rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; called just after a rising edge.
    task automatic drive(input logic [NREQ-1:0] v, input logic rr);
        int              g;
        int              j;
        logic            free;
        logic [NREQ-1:0] exp_rdy;
        check("op_count", 64'(op_count), 64'(m_cnt));
        check("res_valid", 64'(res_valid), 64'(m_rv));
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*AW +: AW] = da[i];
            req_b[i*BW +: BW] = db[i];
        end
        req_valid = v;
        res_ready = rr;
        #1;
        free = !m_rv || rr;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        exp_rdy = '0;
        if (g >= 0 && free) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < NREQ; i++) begin
            if (!v[i] || (exp_rdy != 0 && i == g)) begin
                wait_ops[i] = 0;
            end else if (exp_rdy != 0) begin
                wait_ops[i]++;
                check("fair_wait_exceeded", 64'(wait_ops[i] > NREQ - 1), 64'(0));
            end
        end
        if (exp_rdy != 0) begin
            exp_q.push_back({IDW'(g), PW'(da[g]) * PW'(db[g])});
            m_ptr = (g + 1) % NREQ;
            m_cnt++;
            m_rv = 1'b1;
        end else if (rr) begin
            m_rv = 1'b0;
        end
        last_gnt = exp_rdy;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        ap_rst    = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        exp_q.delete();
        m_ptr = 0;
        m_rv  = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;
        repeat (cycles) begin
            #1;
            check("ready_in_reset", 64'(req_ready), 64'(0));
            @(posedge ap_clk);
            #1;
        end
        ap_rst = 1'b0;
    endtask

    // scoreboard monitor: pops on every output transfer, checks hold under back-pressure
    logic              prev_hold;
    logic [PW-1:0]     prev_data;
    logic [IDW-1:0]    prev_id;
    logic [PW+IDW-1:0] mon_e;

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_data", 64'(res_data), 64'(prev_data));
                check("hold_id", 64'(res_id), 64'(prev_id));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d data=0x%0h want no result", res_id, res_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_id", 64'(res_id), 64'(mon_e[PW+IDW-1:PW]));
                    check("res_data", 64'(res_data), 64'(mon_e[PW-1:0]));
                end
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_id   = res_id;
        end
    end

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        ap_rst    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        last_gnt  = '0;
        rv        = '0;
        prev_hold = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            da[i] = '0;
            db[i] = '0;
            wait_ops[i] = 0;
        end
        @(posedge ap_clk);
        #1;
        do_reset(2);
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_res_id", 64'(res_id), 64'(0));
        check("rst_op_count", 64'(op_count), 64'(0));

        // single requester
        da[0] = 25'd3;
        db[0] = 18'd5;
        drive(4'b0001, 1'b1);
        drive(4'b0000, 1'b1);

        // all requesters streaming
        for (int i = 0; i < NREQ; i++) begin
            da[i] = AW'(i + 1);
            db[i] = 18'd10;
        end
        repeat (8) drive(4'b1111, 1'b1);

        // back-pressure then release
        repeat (3) drive(4'b1111, 1'b0);
        repeat (3) drive(4'b1111, 1'b1);

        // extreme operands
        da[1] = 25'h1FFFFFF;
        db[1] = 18'h3FFFF;
        da[3] = 25'd0;
        db[3] = 18'h3FFFF;
        drive(4'b0010, 1'b1);
        drive(4'b1000, 1'b1);
        drive(4'b0000, 1'b1);

        // reset while a result is held
        da[1] = 25'd7;
        db[1] = 18'd9;
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        do_reset(1);
        check("midrst_res_valid", 64'(res_valid), 64'(0));
        check("midrst_op_count", 64'(op_count), 64'(0));
        da[1] = 25'd2;
        db[1] = 18'd2;
        da[3] = 25'd4;
        db[3] = 18'd4;
        drive(4'b1010, 1'b1);
        drive(4'b0000, 1'b1);

        // requester 0 always valid, requester 2 pulses once
        da[0] = 25'd11;
        db[0] = 18'd13;
        da[2] = 25'd17;
        db[2] = 18'd19;
        drive(4'b0001, 1'b1);
        drive(4'b0101, 1'b1);
        repeat (3) drive(4'b0001, 1'b1);

        // random traffic with sticky requests and random back-pressure
        rv = '0;
        repeat (1000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rv[i] && !last_gnt[i]) rv[i] = ($urandom_range(0, 9) != 0);
                else                       rv[i] = ($urandom_range(0, 1) == 1);
                da[i] = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
                db[i] = ($urandom_range(0, 7) == 0) ? {BW{1'b1}} : BW'($urandom);
            end
            drive(rv, $urandom_range(0, 3) != 0);
        end

        // drain outstanding results
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            drive(4'b0000, 1'b1);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
